// File: rtl/sram_bank_arbiter.sv
// Purpose: shares per-bank single-port operand SRAMs between the DFU read wavefront and the LSU.
// Latency: SRAM command registered 1 cycle after request; read data valid 2 cycles after request.
// Backpressure: LSU waits on lsu_gnt; a starved LSU is forced through by stalling the whole DFU wavefront.
module sram_bank_arbiter #(
  parameter int NUM_BANKS    = 4,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BANKS-1:0]           dfu_rd_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]    dfu_rd_addr,
  output logic                           dfu_stall,
  output logic [NUM_BANKS*DATA_W-1:0]    dfu_rdata,
  output logic [NUM_BANKS-1:0]           dfu_rdata_vld,
  input  logic                           lsu_req,
  input  logic                           lsu_we,
  input  logic [$clog2(NUM_BANKS)-1:0]   lsu_bank,
  input  logic [ADDR_W-1:0]              lsu_addr,
  input  logic [DATA_W-1:0]              lsu_wdata,
  output logic                           lsu_gnt,
  output logic [DATA_W-1:0]              lsu_rdata,
  output logic                           lsu_rdata_vld,
  output logic [NUM_BANKS-1:0]           sram_en,
  output logic [NUM_BANKS-1:0]           sram_we,
  output logic [NUM_BANKS*ADDR_W-1:0]    sram_addr,
  output logic [NUM_BANKS*DATA_W-1:0]    sram_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]    sram_rdata
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  // A limit of 0 still needs a 1-bit counter so the compare below is legal.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  logic                        conflict;
  logic                        force_lsu;
  logic [CNT_W-1:0]            starve_cnt_q;

  logic [NUM_BANKS-1:0]        sram_en_q, sram_en_d;
  logic [NUM_BANKS-1:0]        sram_we_q, sram_we_d;
  logic [NUM_BANKS*ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [NUM_BANKS*DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  owner_e                      owner_q [NUM_BANKS];
  owner_e                      owner_d [NUM_BANKS];

  logic [NUM_BANKS-1:0]        dfu_vld_q, dfu_vld_d;
  logic                        lsu_vld_q, lsu_vld_d;
  logic [BANK_W-1:0]           lsu_sel_q, lsu_sel_d;
  logic [NUM_BANKS*DATA_W-1:0] dfu_hold_q;
  logic [DATA_W-1:0]           lsu_hold_q;
  logic [DATA_W-1:0]           lsu_word;

  // The LSU only contends with the DFU lane on its own target bank.
  assign conflict  = lsu_req && dfu_rd_en[lsu_bank];
  assign force_lsu = conflict && (starve_cnt_q == CNT_MAX);
  assign lsu_gnt   = lsu_req && (!conflict || force_lsu);
  // Stalling drops every DFU lane so the skewed wavefront stays aligned.
  assign dfu_stall = force_lsu;

  // Count consecutive LSU losses; any grant restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else if (lsu_gnt) begin
      starve_cnt_q <= '0;
    end else if (lsu_req && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  // Per-bank command select: LSU grant first, else DFU read unless the wavefront is stalled.
  always_comb begin
    sram_en_d    = '0;
    sram_we_d    = '0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      owner_d[b] = OWN_NONE;
      if (lsu_gnt && (lsu_bank == BANK_W'(b))) begin
        sram_en_d[b]                    = 1'b1;
        sram_we_d[b]                    = lsu_we;
        sram_addr_d[b*ADDR_W +: ADDR_W] = lsu_addr;
        sram_wdata_d[b*DATA_W +: DATA_W] = lsu_wdata;
        // Writes return nothing, so they leave no owner behind.
        owner_d[b]                      = lsu_we ? OWN_NONE : OWN_LSU;
      end else if (dfu_rd_en[b] && !dfu_stall) begin
        sram_en_d[b]                    = 1'b1;
        sram_addr_d[b*ADDR_W +: ADDR_W] = dfu_rd_addr[b*ADDR_W +: ADDR_W];
        owner_d[b]                      = OWN_DFU;
      end
    end
  end

  // Register the SRAM command together with the owner of each access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_en_q    <= '0;
      sram_we_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) owner_q[b] <= OWN_NONE;
    end else begin
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      for (int b = 0; b < NUM_BANKS; b++) owner_q[b] <= owner_d[b];
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

  // Decode the owner of the access now at the SRAM; at most one bank carries an LSU read.
  always_comb begin
    dfu_vld_d = '0;
    lsu_vld_d = 1'b0;
    lsu_sel_d = lsu_sel_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      dfu_vld_d[b] = (owner_q[b] == OWN_DFU);
      if (owner_q[b] == OWN_LSU) begin
        lsu_vld_d = 1'b1;
        lsu_sel_d = BANK_W'(b);
      end
    end
  end

  // Response valids are registered; data is steered from the SRAM in the valid cycle and held after.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dfu_vld_q  <= '0;
      lsu_vld_q  <= 1'b0;
      lsu_sel_q  <= '0;
      dfu_hold_q <= '0;
      lsu_hold_q <= '0;
    end else begin
      dfu_vld_q  <= dfu_vld_d;
      lsu_vld_q  <= lsu_vld_d;
      lsu_sel_q  <= lsu_sel_d;
      dfu_hold_q <= dfu_rdata;
      lsu_hold_q <= lsu_rdata;
    end
  end

  // SRAM data arrives in the cycle after the command, so it cannot be flopped before the valid cycle.
  always_comb begin
    lsu_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      dfu_rdata[b*DATA_W +: DATA_W] = dfu_vld_q[b] ? sram_rdata[b*DATA_W +: DATA_W]
                                                   : dfu_hold_q[b*DATA_W +: DATA_W];
      if (lsu_sel_q == BANK_W'(b)) lsu_word = sram_rdata[b*DATA_W +: DATA_W];
    end
  end

  assign dfu_rdata_vld = dfu_vld_q;
  assign lsu_rdata     = lsu_vld_q ? lsu_word : lsu_hold_q;
  assign lsu_rdata_vld = lsu_vld_q;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter: one instance at STARVE_LIMIT=8, one at STARVE_LIMIT=0.
// Inputs change 1 time unit after the rising edge; outputs are compared in the same low-activity window.
// A behavioural SRAM (1-cycle read latency) sits behind the STARVE_LIMIT=8 instance.
module tb_sram_bank_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   dfu_rd_en;
  logic [39:0]  dfu_rd_addr;
  logic         lsu_req;
  logic         lsu_we;
  logic [1:0]   lsu_bank;
  logic [9:0]   lsu_addr;
  logic [31:0]  lsu_wdata;
  logic [127:0] sram_rdata;

  logic         dfu_stall, lsu_gnt, lsu_rdata_vld;
  logic [127:0] dfu_rdata, sram_wdata;
  logic [3:0]   dfu_rdata_vld, sram_en, sram_we;
  logic [31:0]  lsu_rdata;
  logic [39:0]  sram_addr;

  logic         dfu_stall_z, lsu_gnt_z, lsu_rdata_vld_z;
  logic [127:0] dfu_rdata_z, sram_wdata_z;
  logic [3:0]   dfu_rdata_vld_z, sram_en_z, sram_we_z;
  logic [31:0]  lsu_rdata_z;
  logic [39:0]  sram_addr_z;

  int n_chk;
  int n_fail;

  logic [31:0] mem [4][1024];

  sram_bank_arbiter #(.NUM_BANKS(4), .ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .dfu_rd_en(dfu_rd_en), .dfu_rd_addr(dfu_rd_addr), .dfu_stall(dfu_stall),
    .dfu_rdata(dfu_rdata), .dfu_rdata_vld(dfu_rdata_vld),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_bank(lsu_bank), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rdata(lsu_rdata), .lsu_rdata_vld(lsu_rdata_vld),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  sram_bank_arbiter #(.NUM_BANKS(4), .ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(0)) dut_z (
    .clk(clk), .rst(rst),
    .dfu_rd_en(dfu_rd_en), .dfu_rd_addr(dfu_rd_addr), .dfu_stall(dfu_stall_z),
    .dfu_rdata(dfu_rdata_z), .dfu_rdata_vld(dfu_rdata_vld_z),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_bank(lsu_bank), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt_z), .lsu_rdata(lsu_rdata_z), .lsu_rdata_vld(lsu_rdata_vld_z),
    .sram_en(sram_en_z), .sram_we(sram_we_z), .sram_addr(sram_addr_z), .sram_wdata(sram_wdata_z),
    .sram_rdata(sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Default contents are a recognisable function of bank and address.
  function automatic logic [31:0] mval(input int b, input int a);
    return 32'hC000_0000 + (32'(b) << 16) + 32'(a);
  endfunction

  // Behavioural single-port SRAM per bank, read data valid the cycle after the command.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (sram_en[b]) begin
        if (sram_we[b]) mem[b][sram_addr[b*10 +: 10]] = sram_wdata[b*32 +: 32];
        else            sram_rdata[b*32 +: 32] <= mem[b][sram_addr[b*10 +: 10]];
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dfu_rd_en   = '0;
    dfu_rd_addr = '0;
    lsu_req     = 1'b0;
    lsu_we      = 1'b0;
    lsu_bank    = '0;
    lsu_addr    = '0;
    lsu_wdata   = '0;
  endtask

  task automatic dfu_addr(input int b, input logic [9:0] a);
    dfu_rd_addr[b*10 +: 10] = a;
  endtask

  task automatic lsu(input logic we, input logic [1:0] bank, input logic [9:0] a, input logic [31:0] wd);
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_bank  = bank;
    lsu_addr  = a;
    lsu_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 1024; a++) mem[b][a] = mval(b, a);
    mem[3][10'h3FF] = 32'hDEADBEEF;
    sram_rdata = '0;
    rst = 1'b0;
    idle();
    repeat (3) tick();

    // Reset state
    check("rst_sram_en", sram_en, 4'b0);
    check("rst_sram_we", sram_we, 4'b0);
    check("rst_sram_addr", sram_addr, 40'b0);
    check("rst_sram_wdata", sram_wdata, 128'b0);
    check("rst_dfu_vld", dfu_rdata_vld, 4'b0);
    check("rst_dfu_rdata", dfu_rdata, 128'b0);
    check("rst_lsu_vld", lsu_rdata_vld, 1'b0);
    check("rst_lsu_rdata", lsu_rdata, 32'b0);
    check("rst_starve", dut.starve_cnt_q, 0);
    check("rst_z_sram_en", sram_en_z, 4'b0);
    rst = 1'b1;
    tick();

    // Non-conflicting DFU read bank0 and LSU write bank2
    dfu_rd_en = 4'b0001;
    dfu_addr(0, 10'd5);
    lsu(1'b1, 2'd2, 10'd7, 32'hA5A5A5A5);
    #1;
    check("nc_gnt", lsu_gnt, 1'b1);
    check("nc_stall", dfu_stall, 1'b0);
    tick();
    idle();
    check("nc_en", sram_en, 4'b0101);
    check("nc_we", sram_we, 4'b0100);
    check("nc_addr_b2", sram_addr[29:20], 10'd7);
    check("nc_addr_b0", sram_addr[9:0], 10'd5);
    check("nc_wdata_b2", sram_wdata[95:64], 32'hA5A5A5A5);
    tick();
    check("nc_dfu_vld", dfu_rdata_vld, 4'b0001);
    check("nc_dfu_rdata0", dfu_rdata[31:0], mval(0, 5));
    check("nc_lsu_vld", lsu_rdata_vld, 1'b0);
    check("nc_en_idle", sram_en, 4'b0000);

    // LSU read bank3 top address
    lsu(1'b0, 2'd3, 10'h3FF, 32'h0);
    #1;
    check("rd3_gnt", lsu_gnt, 1'b1);
    tick();
    idle();
    check("rd3_en", sram_en, 4'b1000);
    check("rd3_we", sram_we, 4'b0000);
    check("rd3_addr", sram_addr[39:30], 10'h3FF);
    tick();
    check("rd3_lsu_rdata", lsu_rdata, 32'hDEADBEEF);
    check("rd3_lsu_vld", lsu_rdata_vld, 1'b1);
    check("rd3_dfu_vld", dfu_rdata_vld, 4'b0000);
    tick();
    check("rd3_vld_drop", lsu_rdata_vld, 1'b0);
    check("rd3_hold", lsu_rdata, 32'hDEADBEEF);

    // Read back the earlier LSU write
    lsu(1'b0, 2'd2, 10'd7, 32'h0);
    tick();
    idle();
    tick();
    check("wb_lsu_rdata", lsu_rdata, 32'hA5A5A5A5);
    check("wb_lsu_vld", lsu_rdata_vld, 1'b1);

    // Same-bank ownership switch DFU then LSU
    dfu_rd_en = 4'b0010;
    dfu_addr(1, 10'd20);
    tick();
    idle();
    lsu(1'b0, 2'd1, 10'd30, 32'h0);
    #1;
    check("sw_gnt", lsu_gnt, 1'b1);
    check("sw_stall", dfu_stall, 1'b0);
    tick();
    idle();
    check("sw_dfu_vld", dfu_rdata_vld, 4'b0010);
    check("sw_dfu_rdata1", dfu_rdata[63:32], mval(1, 20));
    check("sw_lsu_vld0", lsu_rdata_vld, 1'b0);
    tick();
    check("sw_lsu_vld1", lsu_rdata_vld, 1'b1);
    check("sw_lsu_rdata", lsu_rdata, mval(1, 30));
    check("sw_dfu_vld_off", dfu_rdata_vld, 4'b0000);
    check("sw_dfu_hold", dfu_rdata[63:32], mval(1, 20));

    // Starvation: DFU holds all banks, LSU reads bank1
    dfu_rd_en = 4'b1111;
    for (int b = 0; b < 4; b++) dfu_addr(b, 10'(40 + b));
    lsu(1'b0, 2'd1, 10'd50, 32'h0);
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("st_cnt_%0d", i), dut.starve_cnt_q, i);
      check($sformatf("st_gnt_%0d", i), lsu_gnt, 1'b0);
      check($sformatf("st_stall_%0d", i), dfu_stall, 1'b0);
      tick();
      check($sformatf("st_en_%0d", i), sram_en, 4'b1111);
    end
    check("st_cnt_lim", dut.starve_cnt_q, 8);
    check("st_gnt_win", lsu_gnt, 1'b1);
    check("st_stall_win", dfu_stall, 1'b1);
    tick();
    idle();
    check("st_en_forced", sram_en, 4'b0010);
    check("st_we_forced", sram_we, 4'b0000);
    check("st_addr_b1", sram_addr[19:10], 10'd50);
    check("st_cnt_clr", dut.starve_cnt_q, 0);
    tick();
    check("st_lsu_vld", lsu_rdata_vld, 1'b1);
    check("st_lsu_rdata", lsu_rdata, mval(1, 50));
    check("st_dfu_vld", dfu_rdata_vld, 4'b0000);

    // Reset in the middle of in-flight reads
    dfu_rd_en = 4'b0010;
    dfu_addr(1, 10'd60);
    lsu(1'b0, 2'd1, 10'd61, 32'h0);
    #1;
    check("mr_gnt", lsu_gnt, 1'b0);
    tick();
    idle();
    check("mr_cnt_pre", dut.starve_cnt_q, 1);
    check("mr_en_pre", sram_en, 4'b0010);
    rst = 1'b0;
    tick();
    check("mr_dfu_vld", dfu_rdata_vld, 4'b0000);
    check("mr_lsu_vld", lsu_rdata_vld, 1'b0);
    check("mr_en", sram_en, 4'b0000);
    check("mr_cnt", dut.starve_cnt_q, 0);
    check("mr_dfu_rdata", dfu_rdata, 128'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mr_late_dfu_%0d", i), dfu_rdata_vld, 4'b0000);
      check($sformatf("mr_late_lsu_%0d", i), lsu_rdata_vld, 1'b0);
    end

    // STARVE_LIMIT=0 instance: LSU wins any conflict at once
    dfu_rd_en = 4'b0101;
    dfu_addr(0, 10'd70);
    dfu_addr(2, 10'd71);
    lsu(1'b1, 2'd2, 10'd9, 32'h12345678);
    #1;
    check("z_gnt", lsu_gnt_z, 1'b1);
    check("z_stall", dfu_stall_z, 1'b1);
    check("z_ref_gnt", lsu_gnt, 1'b0);
    check("z_ref_stall", dfu_stall, 1'b0);
    tick();
    idle();
    check("z_en", sram_en_z, 4'b0100);
    check("z_we", sram_we_z, 4'b0100);
    check("z_addr_b2", sram_addr_z[29:20], 10'd9);
    check("z_wdata_b2", sram_wdata_z[95:64], 32'h12345678);
    check("z_ref_en", sram_en, 4'b0101);
    check("z_ref_we", sram_we, 4'b0000);
    check("z_ref_cnt", dut.starve_cnt_q, 1);
    tick();
    check("z_dfu_vld", dfu_rdata_vld_z, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
Shares the per-bank single-port operand SRAMs between the data fetch unit's streaming read wavefront (DFU) and the load/store unit (LSU) that fills and drains the banks. The DFU has default priority. A starvation counter guarantees the LSU forward progress by stalling the whole DFU wavefront for one cycle when it wins. The block registers the SRAM command and routes returned read data back to the owner of each access.

Parameters:
NUM_BANKS, 4, number of SRAM banks
ADDR_W, 10, SRAM word address width
DATA_W, 32, SRAM data width
STARVE_LIMIT, 8, number of consecutive LSU conflict losses tolerated before the LSU is forced through (0 = LSU always wins a conflict)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
dfu_rd_en  in  NUM_BANKS  per-bank DFU read request
dfu_rd_addr  in  NUM_BANKS*ADDR_W  per-bank DFU read address, bank b at [b*ADDR_W +: ADDR_W]
dfu_stall  out  1  combinational; DFU must hold its entire request vector unchanged next cycle
dfu_rdata  out  NUM_BANKS*DATA_W  per-bank read data to DFU
dfu_rdata_vld  out  NUM_BANKS  per-bank DFU read data valid
lsu_req  in  1  LSU access request; held stable until granted
lsu_we  in  1  1 = write, 0 = read
lsu_bank  in  $clog2(NUM_BANKS)  target bank
lsu_addr  in  ADDR_W  target address
lsu_wdata  in  DATA_W  write data
lsu_gnt  out  1  combinational grant, same cycle as lsu_req
lsu_rdata  out  DATA_W  LSU read data
lsu_rdata_vld  out  1  LSU read data valid
sram_en  out  NUM_BANKS  registered bank enable
sram_we  out  NUM_BANKS  registered bank write enable
sram_addr  out  NUM_BANKS*ADDR_W  registered bank address
sram_wdata  out  NUM_BANKS*DATA_W  registered bank write data
sram_rdata  in  NUM_BANKS*DATA_W  bank read data, valid one cycle after sram_en with sram_we=0

Behaviour:
- Single clock clk. Reset is synchronous, active-low on rst.
- Reset values:
  - sram_en, sram_we, sram_addr, sram_wdata = 0
  - dfu_rdata, dfu_rdata_vld = 0
  - lsu_rdata, lsu_rdata_vld = 0
  - starve_cnt = 0
  - owner pipeline cleared
- Reset mid-operation: in-flight reads are discarded; no vld pulses appear after reset.
- Conflict definition: lsu_req && dfu_rd_en[lsu_bank].
- Arbitration (combinational, request cycle N):
  - No conflict: lsu_gnt=lsu_req; all DFU requests pass; dfu_stall=0.
  - Conflict, starve_cnt < STARVE_LIMIT: DFU wins; lsu_gnt=0; dfu_stall=0.
  - Conflict, starve_cnt == STARVE_LIMIT: LSU wins; lsu_gnt=1; dfu_stall=1. While dfu_stall=1, all DFU requests on every bank are dropped that cycle, which keeps the skewed wavefront aligned.
- dfu_stall is never asserted without a conflict.
- starve_cnt (width $clog2(STARVE_LIMIT+1), minimum 1):
  - Increments when lsu_req && !lsu_gnt.
  - Clears on lsu_gnt.
  - Holds when lsu_req=0.
  - Never exceeds STARVE_LIMIT.
- Command stage (registered at N+1), per bank b:
  - sram_en[b] = granted DFU read on b or granted LSU access on b.
  - sram_we[b] = 1 only for an LSU write.
  - sram_addr[b] and sram_wdata[b] are taken from the granted source.
  - Idle banks get en=0, we=0; addr and wdata hold their last value.
- Owner tracking: a per-bank 2-bit register captured with the command (none / DFU / LSU-read). LSU writes record none.
- Response stage (registered at N+2):
  - Owner DFU: dfu_rdata_vld[b]=1, dfu_rdata[b]=sram_rdata[b].
  - Owner LSU: lsu_rdata_vld=1, lsu_rdata=sram_rdata[lsu bank].
  - Data outputs hold when not valid.
  - Read latency from request to valid is exactly 2 cycles for both requesters.
  - At most one LSU access is in flight per cycle, so LSU responses never collide.
- Back-to-back accesses to the same bank by different owners are legal every cycle; routing follows the owner registered for each cycle.
- A write and a read to the same bank are never both issued, because arbitration is per bank.
- LSU protocol violation (request fields change before gnt) is undefined and is not checked.

Test Plan:
- Non-conflicting access: DFU reads bank0 addr 5 and LSU writes bank2 addr 7 data 0xA5A5A5A5 in cycle N → lsu_gnt=1 at N. At N+1: sram_en=4'b0101, sram_we=4'b0100, sram_addr bank2=7. At N+2: dfu_rdata_vld=4'b0001, lsu_rdata_vld=0.
- Starvation with STARVE_LIMIT=8: dfu_rd_en[1] held high and LSU reads bank1 continuously → lsu_gnt low for 8 cycles. On the 9th request cycle: lsu_gnt=1, dfu_stall=1, sram_en=0 on the other DFU banks at the next cycle, starve_cnt back to 0.
- LSU read bank3 addr 0x3FF with the SRAM model returning 0xDEADBEEF → at N+2: lsu_rdata=0xDEADBEEF, lsu_rdata_vld=1, dfu_rdata_vld=0.
- Same-bank ownership switch: DFU reads bank1 at N, LSU reads bank1 at N+1 (DFU idle) → dfu_rdata_vld[1] at N+2, lsu_rdata_vld at N+3, each with its own address's data.
- rst driven low at N+1 with reads issued at N → at N+2: all vld=0, sram_en=0, starve_cnt=0, and no late pulses.
- STARVE_LIMIT=0 with a conflict at N → lsu_gnt=1, dfu_stall=1 at N, and the DFU request on that bank is not issued at N+1.
